// File: rtl/peripheral_uart_rx_if.sv
// J1 I/O bus view of the UART receiver peripheral.
//   cs     : chip-select from the top-level address decoder
//   addr   : register address (j1_io_addr[3:0])
//   rd/wr  : one-cycle read / write strobes
//   d_in   : write data from the J1
//   d_out  : registered read data towards the j1_io_din mux
//   rx_irq : receiver interrupt request
interface peripheral_uart_rx_if;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        rx_irq;

    modport master (output cs, addr, rd, wr, d_in, input d_out, rx_irq);
    modport slave  (input cs, addr, rd, wr, d_in, output d_out, rx_irq);
endinterface

// File: rtl/peripheral_uart_rx.sv
// UART receiver peripheral: deserialises 8N1 frames from an asynchronous line and queues the
// bytes in a small FIFO that the J1 reads over its I/O bus.
//   sys_clk_i : system clock, rising edge
//   sys_rst_i : asynchronous active-low reset
//   uart_rx   : serial line, idle high, asynchronous to sys_clk_i
//   bus       : J1 register port (slave side), see peripheral_uart_rx_if
// Registers: 0x0 R DATA (pops), 0x2 R STATUS, 0x4 R LEVEL, 0x4 W CTRL (flush / clear flags).
module peripheral_uart_rx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 uart_rx,
    peripheral_uart_rx_if.slave  bus
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = $clog2(BIT_CYC);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] CntHalf = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BIT_CYC - 1);
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // Line synchroniser plus one delayed copy for falling-edge detection.
    logic sync1_q, sync2_q, prev_q;
    logic fall;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Only an edge starts a frame, so a held break cannot retrigger.
    assign fall = prev_q & ~sync2_q;

    // Receive FSM.
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req, frame_set;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = StStop;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (sync2_q) push_req  = 1'b1;
                    else         frame_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Bus decode.
    logic rd_sel, ctrl_wr, flush, clr_ov, clr_fe;
    assign rd_sel  = bus.cs & bus.rd;
    assign ctrl_wr = bus.cs & bus.wr & (bus.addr == 4'h4);
    assign flush   = ctrl_wr & bus.d_in[0];
    assign clr_ov  = ctrl_wr & bus.d_in[1];
    assign clr_fe  = ctrl_wr & bus.d_in[2];

    logic unused_d_in;
    assign unused_d_in = ^bus.d_in[15:3];

    // FIFO; occupancy is tracked by a counter so full/empty never need pointer compare.
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             ov_q, ov_d, fe_q, fe_d, irq_q;
    logic             empty, full, pop, do_push, ov_set;
    logic [15:0]      d_out_q, d_out_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == LvlFull);
    assign pop   = rd_sel & (bus.addr == 4'h0) & ~empty;
    // A pop on the same edge frees the slot the push needs; a flush swallows the push silently.
    assign do_push = push_req & (~full | pop) & ~flush;
    assign ov_set  = push_req & full & ~pop & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
        // Set beats a same-edge clear.
        ov_d = ov_set | (ov_q & ~clr_ov);
        fe_d = frame_set | (fe_q & ~clr_fe);
    end

    always_comb begin
        d_out_d = d_out_q;
        if (rd_sel) begin
            case (bus.addr)
                4'h0:    d_out_d = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
                4'h2:    d_out_d = {11'b0, fe_q, ov_q, full, (state_q != StIdle), ~empty};
                4'h4:    d_out_d = 16'(count_q);
                default: d_out_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
            fe_q     <= 1'b0;
            irq_q    <= 1'b0;
            d_out_q  <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ov_q     <= ov_d;
            fe_q     <= fe_d;
            irq_q    <= (count_d != '0) | ov_d | fe_d;
            d_out_q  <= d_out_d;
        end
    end

    // Storage needs no reset; occupancy count guards every read.
    always_ff @(posedge sys_clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.d_out  = d_out_q;
    assign bus.rx_irq = irq_q;

endmodule

// File: tb/tb_peripheral_uart_rx.sv
module tb_peripheral_uart_rx;

    localparam int BIT_CYC = 16;
    localparam int DEPTH   = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rx_line = 1'b1;

    peripheral_uart_rx_if bus_if ();

    peripheral_uart_rx #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst_n),
        .uart_rx   (rx_line),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus sticky flags.
    byte unsigned mq[$];
    bit           m_ov = 1'b0;
    bit           m_fe = 1'b0;

    typedef struct {
        int          kind;   // 0 send byte, 1 read, 2 write
        logic [3:0]  addr;
        logic [15:0] data;
        bit          stop;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int k, logic [3:0] a, logic [15:0] d, bit s, logic [15:0] e);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.stop = s; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] b, input bit stop);
        if (!stop)                 m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else                       m_ov = 1'b1;
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
        logic [15:0] r;
        case (a)
            4'h0: r = (mq.size() != 0) ? {8'h00, mq.pop_front()} : 16'h0000;
            4'h2: r = {11'b0, m_fe, m_ov, (mq.size() == DEPTH), 1'b0, (mq.size() != 0)};
            4'h4: r = 16'(mq.size());
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [15:0] d);
        if (a == 4'h4) begin
            if (d[0]) mq.delete();
            if (d[1]) m_ov = 1'b0;
            if (d[2]) m_fe = 1'b0;
        end
    endfunction

    function automatic logic [15:0] model_irq();
        return {15'b0, (mq.size() != 0) | m_ov | m_fe};
    endfunction

    // All bus and line tasks start and end on a falling clock edge.
    task automatic bus_read(input logic [3:0] a, output logic [15:0] d, output logic irq);
        bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
        @(negedge clk);
        d = bus_if.d_out; irq = bus_if.rx_irq;
        bus_if.cs = 1'b0; bus_if.rd = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.d_in = d;
        @(negedge clk);
        bus_if.cs = 1'b0; bus_if.wr = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_read(input string name, input logic [3:0] a);
        logic [15:0] d, e;
        logic        irq;
        bus_read(a, d, irq);
        e = model_read(a);
        check(name, d, e);
        check({name, "_irq"}, {15'b0, irq}, model_irq());
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx_line = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx_line = stop;
        repeat (BIT_CYC) @(negedge clk);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        model_push(b, stop);
    endtask

    logic [15:0] rd_d, e2, d2;
    logic        rd_irq, i2;

    initial begin
        // Directed vectors; expected values worked out by hand.
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h4, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h0, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(0, 4'h0, 16'hA5, 1, 16'h0000));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0001));
        tbl.push_back(mk(1, 4'h0, 16'h0, 0, 16'h00A5));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(0, 4'h0, 16'h3C, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0010));
        tbl.push_back(mk(2, 4'h4, 16'h0004, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0000));
        for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 4'h0, 16'(i), 1, 16'h0000));
        tbl.push_back(mk(1, 4'h4, 16'h0, 0, 16'h0008));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h000D));
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 4'h0, 16'h0, 0, 16'(i)));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0008));
        tbl.push_back(mk(2, 4'h4, 16'h0002, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(0, 4'h0, 16'h11, 1, 16'h0000));
        tbl.push_back(mk(0, 4'h0, 16'h22, 1, 16'h0000));
        tbl.push_back(mk(1, 4'h4, 16'h0, 0, 16'h0002));
        tbl.push_back(mk(2, 4'h4, 16'h0001, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h4, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h6, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(2, 4'h8, 16'hFFFF, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h2, 16'h0, 0, 16'h0000));
        tbl.push_back(mk(1, 4'h1, 16'h0, 0, 16'h0000));

        bus_if.cs = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
        bus_if.addr = 4'h0; bus_if.d_in = 16'h0000;

        repeat (3) @(negedge clk);
        check("reset_dout", bus_if.d_out, 16'h0000);
        check("reset_irq", {15'b0, bus_if.rx_irq}, 16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                0: send_byte(tbl[i].data[7:0], tbl[i].stop);
                1: begin
                    bus_read(tbl[i].addr, rd_d, rd_irq);
                    e2 = model_read(tbl[i].addr);
                    check($sformatf("tbl[%0d]", i), rd_d, tbl[i].exp);
                    check($sformatf("tbl[%0d]_irq", i), {15'b0, rd_irq}, model_irq());
                end
                default: bus_write(tbl[i].addr, tbl[i].data);
            endcase
        end

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                send_byte(8'($urandom), ($urandom_range(0, 5) != 0));
            end else if (r < 8) begin
                int k;
                logic [3:0] a;
                k = $urandom_range(0, 4);
                a = (k == 0) ? 4'h0 : (k == 1) ? 4'h2 : (k == 2) ? 4'h4 :
                    (k == 3) ? 4'h1 : 4'h6;
                do_read($sformatf("rnd%0d_a%0h", n, a), a);
            end else begin
                bus_write(($urandom_range(0, 3) != 0) ? 4'h4 : 4'h6,
                          16'($urandom_range(0, 7)));
            end
        end

        // Glitch: short low pulse starts then aborts the START phase.
        bus_write(4'h4, 16'h0007);
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(4'h2, rd_d, rd_irq);
        check("glitch_busy", rd_d, 16'h0002);
        repeat (30) @(negedge clk);
        do_read("glitch_status", 4'h2);
        do_read("glitch_level", 4'h4);

        // Reset in the middle of DATA discards the partial byte.
        send_byte(8'h33, 1'b1);
        do_read("pre_rst_level", 4'h4);
        rx_line = 1'b0;
        repeat (BIT_CYC * 4) @(negedge clk);
        rst_n = 1'b0;
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_dout", bus_if.d_out, 16'h0000);
        check("midrst_irq", {15'b0, bus_if.rx_irq}, 16'h0000);
        mq.delete(); m_ov = 1'b0; m_fe = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h5A, 1'b1);
        bus_read(4'h4, rd_d, rd_irq);
        e2 = model_read(4'h4);
        check("post_rst_level", rd_d, 16'h0001);
        bus_read(4'h0, rd_d, rd_irq);
        e2 = model_read(4'h0);
        check("post_rst_data", rd_d, 16'h005A);

        // Full FIFO, pop on the edge where the next stop bit is sampled.
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h41 + i), 1'b1);
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (154) @(negedge clk);
                bus_read(4'h0, d2, i2);
                e2 = model_read(4'h0);
                check("pop_at_stop", d2, 16'h0041);
            end
        join
        bus_read(4'h4, rd_d, rd_irq);
        e2 = model_read(4'h4);
        check("pop_push_level", rd_d, 16'h0008);
        bus_read(4'h2, rd_d, rd_irq);
        e2 = model_read(4'h2);
        check("pop_push_status", rd_d, 16'h0005);
        for (int i = 0; i < DEPTH; i++) do_read($sformatf("drain%0d", i), 4'h0);
        do_read("final_status", 4'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
